spike_aer_arbiter: RTL

SPIKE_AER_ARBITER -- requirements
Module: spike_aer_arbiter

---
 rtl/spike_aer_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spike_aer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spike_aer_arbiter
// Purpose  : Collects one-cycle spike pulses from a neuron array, arbitrates
//            them round-robin (one grant per cycle) and queues the winning
//            neuron indices as address events in a small FIFO drained by a
//            valid/ready consumer. Colliding spikes on an already pending
//            neuron merge and raise a sticky overflow flag.
// Options  : AER_TIMESTAMP_EN - when defined, a free-running TS_WIDTH-bit
//            counter stamps each event at its push edge and the head stamp
//            is presented on aer_ts.
// Revision : 1.0 - initial release
// ============================================================================
module spike_aer_arbiter #(
    parameter int NUM_NEURONS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TS_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_NEURONS-1:0]         spike_in,
    input  logic                           aer_ready,
    output logic                           aer_valid,
    output logic [$clog2(NUM_NEURONS)-1:0] aer_addr,
    output logic                           overflow,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_WIDTH-1:0]            aer_ts,
`endif
    output logic                           busy
);

    localparam int ADDR_W = $clog2(NUM_NEURONS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [NUM_NEURONS-1:0] ONE_HOT_LSB = {{(NUM_NEURONS-1){1'b0}}, 1'b1};

    // Elaboration-time parameter sanity checks
    if ((NUM_NEURONS < 2) || (NUM_NEURONS > 16) ||
        ((NUM_NEURONS & (NUM_NEURONS - 1)) != 0)) begin : g_bad_num_neurons
        $error("NUM_NEURONS must be a power of two in 2..16");
    end
    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (TS_WIDTH < 1) begin : g_bad_ts_width
        $error("TS_WIDTH must be at least 1");
    end

    logic [NUM_NEURONS-1:0] pend;
    logic [NUM_NEURONS-1:0] req;
    logic [NUM_NEURONS-1:0] pend_next;
    logic [ADDR_W-1:0]      rr_ptr;
    logic [ADDR_W-1:0]      winner;
    logic [ADDR_W-1:0]      idx;
    logic                   found;
    logic                   push_ok;
    logic                   grant;
    logic                   pop;
    logic                   lost;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [ADDR_W-1:0]      addr_mem [FIFO_DEPTH];

    // A spike that lands on an already pending neuron merges with it
    assign req       = pend | spike_in;
    assign lost      = |(pend & spike_in);
    assign aer_valid = (count != '0);
    assign pop       = aer_valid & aer_ready;
    // A full FIFO can still accept a push when the head leaves on the same edge
    assign push_ok   = (count < DEPTH_CNT) | pop;
    assign grant     = (|req) & push_ok;
    assign busy      = (|pend) | aer_valid;
    // Output forced to zero when empty so reset clears it without touching the RAM
    assign aer_addr  = aer_valid ? addr_mem[rd_ptr] : '0;

    // Round-robin search: first request at or above rr_ptr, wrapping upward
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            idx = rr_ptr + ADDR_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Pending vector keeps every ungranted request
    always_comb begin
        pend_next = req;
        if (grant) begin
            pend_next = req & ~(ONE_HOT_LSB << winner);
        end
    end

    // Arbiter and FIFO control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pend <= pend_next;
            if (grant) begin
                rr_ptr <= winner + ADDR_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({grant, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (lost) begin
                overflow <= 1'b1;
            end
        end
    end

    // Event address storage; pointers alone define validity, so no reset
    always_ff @(posedge clk) begin
        if (grant) begin
            addr_mem[wr_ptr] <= winner;
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_mem [FIFO_DEPTH];

    assign aer_ts = aer_valid ? ts_mem[rd_ptr] : '0;

    // Free-running timestamp, wraps naturally at its maximum value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
        end
    end

    // Stamp captured alongside the address at the push edge
    always_ff @(posedge clk) begin
        if (grant) begin
            ts_mem[wr_ptr] <= ts_cnt;
        end
    end
`endif

endmodule
`default_nettype wire
